data_ram_arbiter: RTL and testbench
===================================

// Module: data_ram_arbiter
// PURPOSE
//  Two-master arbiter for the single-port data RAM (sync byte-lane write, comb read).
//  Master 0 = MEM-stage load/store port; master 1 = loader/DMA port.
//  Registered round-robin grant with optional bounded lock for multi-beat bursts.
//  Drives the RAM ce/we/addr/sel/data_i pins; returns read data and a per-master ack.
// PARAMETERS
//  ADDR_W     32  byte-address width of each master and of the RAM port
//  DATA_W     32  data width; sel is DATA_W/8 bits
//  MAX_BURST  4   max consecutive locked grant cycles for one master (>=1)
// PORTS
//  clk          in   1        system clock, all state on posedge
//  rst_n        in   1        asynchronous active-low reset
//  m0_req       in   1        master 0 access request, held until m0_ack
//  m0_we        in   1        1 = write, 0 = read
//  m0_lock      in   1        request to retain grant after this beat
//  m0_addr      in   ADDR_W   byte address
//  m0_sel       in   DATA_W/8 byte-lane enables (write only)
//  m0_wdata     in   DATA_W   write data
//  m0_ack       out  1        access performed this cycle
//  m0_rdata     out  DATA_W   read data, valid only while m0_ack=1 and m0_we=0
//  m1_*         -    -        identical set for master 1
//  m0_gnt/m1_gnt out 1        registered ownership indication
//  ram_ce,ram_we out 1        RAM chip/write enable
//  ram_addr     out  ADDR_W   RAM address
//  ram_sel      out  DATA_W/8 RAM byte-lane enables
//  ram_wdata    out  DATA_W   RAM write data
//  ram_rdata    in   DATA_W   RAM combinational read data
// BEHAVIOUR
//  States: IDLE, OWN0, OWN1 (registered); m0_gnt=(OWN0), m1_gnt=(OWN1).
//  Reset (rst_n=0, any time): state=IDLE, last=1 (so m0 wins first tie),
//   hold_cnt=0; all outputs 0 while in IDLE; in-flight beat dropped, no ack.
//  IDLE: no req -> IDLE; only mX req -> OWNX; both -> OWN(!last).
//  OWNX: mX_ack = mX_req (comb); RAM pins muxed from master X when mX_req,
//   else ram_ce=0 and ram_we/addr/sel/wdata=0. Non-owner ack/rdata = 0.
//  Next state from OWNX:
//   mX_req & mX_lock & hold_cnt<MAX_BURST-1 -> OWNX, hold_cnt++;
//   else other req -> OWN(other), hold_cnt=0, last=X;
//   else mX_req -> OWNX, hold_cnt=0 (no contention, lock limit irrelevant);
//   else -> IDLE, hold_cnt=0, last=X.
//  Latency: req raised in cycle N from IDLE -> gnt+ack in N+1; streaming owner
//   gets ack every cycle; loser of a tie waits >= 1 beat, <= MAX_BURST beats.
//  Write commits at posedge ending the ack cycle; read data = ram_rdata in ack cycle.
//  ram_we = mX_we & mX_req of owner; ram_ce never high outside OWNX.
//  Owner dropping req without ack: no RAM access, leaves per rules above.
//  hold_cnt width $clog2(MAX_BURST)+1; saturates, never wraps.
//  Inputs from a non-owner are ignored; they must stay stable until ack.
// TESTING
//  T1 reset: rst_n=0 mid-OWN1 write -> same cycle gnt=0,ram_ce=0,no RAM write.
//  T2 single: m0 write addr 0x10 sel 4'b0011 data 0xAABBCCDD -> ack next cycle,
//   then m0 read 0x10 -> rdata lanes[15:0]=0xCCDD, upper lanes unchanged.
//  T3 tie: m0,m1 req same cycle after reset -> grants 0,1,0,1 alternating per beat.
//  T4 lock: m1 req+lock 6 beats, m0 req waiting, MAX_BURST=4 -> m1 acks 4 beats,
//   m0 ack on beat 5, m1 resumes beat 6.
//  T5 lock uncontended: m0 lock 10 beats, m1 idle -> 10 consecutive m0 acks.
//  T6 drop: owner drops req w/o other req -> IDLE next cycle, ram_ce=0.

Source files
------------

// File: rtl/data_ram_arbiter_if.sv
// Purpose: one master's request/response bundle toward the data RAM arbiter.
// Latency: none, this is wiring only.
// Backpressure: the master holds req and its payload stable until ack returns.
interface data_ram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  we;
    logic                  lock;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   sel;
    logic [DATA_W-1:0]     wdata;
    logic                  ack;
    logic [DATA_W-1:0]     rdata;
    logic                  gnt;

    modport master (
        output req, we, lock, addr, sel, wdata,
        input  ack, rdata, gnt
    );

    modport slave (
        input  req, we, lock, addr, sel, wdata,
        output ack, rdata, gnt
    );
endinterface

// File: rtl/data_ram_arbiter.sv
// Purpose: round-robin two-master arbiter for the single-port data RAM, with bounded burst lock.
// Latency: a request from idle is granted and acked the next cycle; the owner is acked every cycle it requests.
// Backpressure: a non-owner waits with req held (at most MAX_BURST beats); ack is the only completion signal.
module data_ram_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    data_ram_arbiter_if.slave   m0,
    data_ram_arbiter_if.slave   m1,
    output logic                ram_ce,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W/8-1:0] ram_sel,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t           state, state_nx;
    logic             last, last_nx;       // 1 = master 1 was the most recent owner
    logic [CNT_W-1:0] hold_cnt, hold_nx;   // locked beats already granted back-to-back

    // Owner-relative view of the two masters, so both OWN states share one rule set.
    logic                own1;
    logic                owning;
    logic                own_req, own_lock, own_we, oth_req;
    logic [ADDR_W-1:0]   own_addr;
    logic [DATA_W/8-1:0] own_sel;
    logic [DATA_W-1:0]   own_wdata;
    logic                access;

    assign own1      = (state == OWN1);
    assign owning    = (state == OWN0) || (state == OWN1);
    assign own_req   = own1 ? m1.req   : m0.req;
    assign own_lock  = own1 ? m1.lock  : m0.lock;
    assign own_we    = own1 ? m1.we    : m0.we;
    assign own_addr  = own1 ? m1.addr  : m0.addr;
    assign own_sel   = own1 ? m1.sel   : m0.sel;
    assign own_wdata = own1 ? m1.wdata : m0.wdata;
    assign oth_req   = own1 ? m0.req   : m1.req;
    assign access    = owning && own_req;

    // Arbitration state; reset drops any in-flight beat immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            last     <= last_nx;
            hold_cnt <= hold_nx;
        end
    end

    // Next owner: a locked burst is honoured up to MAX_BURST beats, then the waiter gets a turn.
    always_comb begin
        state_nx = state;
        last_nx  = last;
        hold_nx  = '0;
        case (state)
            IDLE: begin
                if (m0.req && m1.req) state_nx = last ? OWN0 : OWN1;
                else if (m0.req)      state_nx = OWN0;
                else if (m1.req)      state_nx = OWN1;
            end
            OWN0, OWN1: begin
                if (own_req && own_lock && (hold_cnt < HOLD_MAX)) begin
                    hold_nx = hold_cnt + 1'b1;
                end else if (oth_req) begin
                    state_nx = own1 ? OWN0 : OWN1;
                    last_nx  = own1;
                end else if (!own_req) begin
                    state_nx = IDLE;
                    last_nx  = own1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // RAM pins follow the owner only while it actually requests; otherwise everything is quiet.
    always_comb begin
        ram_ce    = access;
        ram_we    = access && own_we;
        ram_addr  = access ? own_addr  : '0;
        ram_sel   = access ? own_sel   : '0;
        ram_wdata = access ? own_wdata : '0;
    end

    assign m0.gnt   = (state == OWN0);
    assign m1.gnt   = (state == OWN1);
    assign m0.ack   = (state == OWN0) && m0.req;
    assign m1.ack   = (state == OWN1) && m1.req;
    assign m0.rdata = (m0.ack && !m0.we) ? ram_rdata : '0;
    assign m1.rdata = (m1.ack && !m1.we) ? ram_rdata : '0;
endmodule

// File: tb/tb_data_ram_arbiter.sv
// Purpose: bench for data_ram_arbiter with a small RAM behind it and a behavioural arbitration model.
// Latency: inputs are driven on the falling edge and outputs sampled 1 ns later.
// Backpressure: bench masters hold each request until the model says it was acked.
module tb_data_ram_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ram_ce, ram_we;
    logic [AW-1:0] ram_addr;
    logic [SW-1:0] ram_sel;
    logic [DW-1:0] ram_wdata, ram_rdata;

    data_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    data_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

    data_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0        (m0_if),
        .m1        (m1_if),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_sel   (ram_sel),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return {8'(i), 8'(i) ^ 8'h5A, 8'hC3, 8'(i * 3)};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
        return r;
    endfunction

    // Bench RAM: synchronous byte-lane write, combinational read, 16 words.
    logic [DW-1:0] mem [16];
    logic          mem_init = 1'b0;
    assign ram_rdata = mem[ram_addr[5:2]];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else if (ram_ce && ram_we) begin
            mem[ram_addr[5:2]] <= merge(mem[ram_addr[5:2]], ram_wdata, ram_sel);
        end
    end

    // Reference model: who owns the RAM, who won last, how long the current locked run is.
    int          owner = -1;
    int          last_win = 1;
    int          streak = 0;
    logic [31:0] exp_mem [16];
    int          n_tests = 0;
    int          n_fail = 0;
    logic        exp_ack0, exp_ack1, obs_ack0, obs_ack1, obs_gnt0, obs_gnt1, obs_ce;
    logic [31:0] obs_rd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        last_win = 1;
        streak = 0;
    endtask

    task automatic drive(input int k, input logic req, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] wdata);
        if (k == 0) begin
            m0_if.req = req; m0_if.we = we; m0_if.lock = lock;
            m0_if.addr = addr; m0_if.sel = sel; m0_if.wdata = wdata;
        end else begin
            m1_if.req = req; m1_if.we = we; m1_if.lock = lock;
            m1_if.addr = addr; m1_if.sel = sel; m1_if.wdata = wdata;
        end
    endtask

    task automatic idle_inputs();
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // One clock: check outputs against the model for the inputs already driven, then advance.
    task automatic cycle();
        logic        r0, r1, ew;
        logic [31:0] ea, ed;
        logic [3:0]  es;
        int          nxt;
        #1;
        r0 = m0_if.req;
        r1 = m1_if.req;
        exp_ack0 = (owner == 0) && r0;
        exp_ack1 = (owner == 1) && r1;
        obs_ack0 = m0_if.ack;  obs_ack1 = m1_if.ack;
        obs_gnt0 = m0_if.gnt;  obs_gnt1 = m1_if.gnt;
        obs_ce = ram_ce;       obs_rd0 = m0_if.rdata;
        ew = 1'b0; ea = 32'h0; es = 4'h0; ed = 32'h0;
        if (exp_ack0) begin ew = m0_if.we; ea = m0_if.addr; es = m0_if.sel; ed = m0_if.wdata; end
        if (exp_ack1) begin ew = m1_if.we; ea = m1_if.addr; es = m1_if.sel; ed = m1_if.wdata; end
        check("gnt0", 32'(obs_gnt0), 32'(owner == 0));
        check("gnt1", 32'(obs_gnt1), 32'(owner == 1));
        check("ack0", 32'(obs_ack0), 32'(exp_ack0));
        check("ack1", 32'(obs_ack1), 32'(exp_ack1));
        check("ram_ce", 32'(obs_ce), 32'(exp_ack0 || exp_ack1));
        check("ram_we", 32'(ram_we), 32'(ew));
        check("ram_addr", ram_addr, ea);
        check("ram_sel", 32'(ram_sel), 32'(es));
        check("ram_wdata", ram_wdata, ed);
        if (exp_ack0 && !m0_if.we) check("rdata0", m0_if.rdata, exp_mem[m0_if.addr[5:2]]);
        if (exp_ack1 && !m1_if.we) check("rdata1", m1_if.rdata, exp_mem[m1_if.addr[5:2]]);
        if (owner != 0) check("rdata0_idle", m0_if.rdata, 32'h0);
        if (owner != 1) check("rdata1_idle", m1_if.rdata, 32'h0);
        if ((exp_ack0 || exp_ack1) && ew) exp_mem[ea[5:2]] = merge(exp_mem[ea[5:2]], ed, es);
        // Ownership for the next cycle.
        if (owner < 0) begin
            if (r0 && r1)  owner = (last_win == 1) ? 0 : 1;
            else if (r0)   owner = 0;
            else if (r1)   owner = 1;
            streak = 0;
        end else begin
            logic mine_req, mine_lock, other_req;
            mine_req  = (owner == 0) ? r0 : r1;
            mine_lock = (owner == 0) ? m0_if.lock : m1_if.lock;
            other_req = (owner == 0) ? r1 : r0;
            nxt = owner;
            if (mine_req && mine_lock && streak < MB - 1) begin
                streak++;
            end else if (other_req) begin
                last_win = owner; nxt = 1 - owner; streak = 0;
            end else if (mine_req) begin
                streak = 0;
            end else begin
                last_win = owner; nxt = -1; streak = 0;
            end
            owner = nxt;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("rst_gnt0", 32'(m0_if.gnt), 32'h0);
        check("rst_gnt1", 32'(m1_if.gnt), 32'h0);
        check("rst_ce", 32'(ram_ce), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int          a0, a1;
        int          seq [$];
        int          exp_seq [7] = '{1, 1, 1, 1, 0, 1, 1};
        logic [31:0] w;
        logic        pend [2];
        logic        t_we [2], t_lock [2];
        logic [31:0] t_addr [2], t_wd [2];
        logic [3:0]  t_sel [2];

        for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // T1: reset asserted while master 1 owns the RAM mid-write.
        drive(1, 1'b1, 1'b1, 1'b0, 32'h24, 4'hF, 32'hDEADBEEF);
        cycle();
        rst_n = 1'b0;
        #1;
        check("t1_gnt1", 32'(m1_if.gnt), 32'h0);
        check("t1_ce", 32'(ram_ce), 32'h0);
        check("t1_ack1", 32'(m1_if.ack), 32'h0);
        @(posedge clk);
        #1;
        check("t1_nowrite", mem[9], exp_mem[9]);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // T2: partial-lane write then read back.
        drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 4'b0011, 32'hAABBCCDD);
        cycle();
        check("t2_noack_first", 32'(obs_ack0), 32'h0);
        cycle();
        check("t2_wr_ack", 32'(obs_ack0), 32'h1);
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 4'h0, 32'h0);
        cycle();
        check("t2_rd_ack", 32'(obs_ack0), 32'h1);
        check("t2_lo", 32'(obs_rd0[15:0]), 32'h0000CCDD);
        w = init_word(4);
        check("t2_hi", 32'(obs_rd0[31:16]), 32'(w[31:16]));
        idle_inputs();
        cycle();

        // T3: simultaneous requests after reset alternate beat by beat, m0 first.
        do_reset();
        drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h4, 4'h0, 32'h0);
        cycle();
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("t3_gnt", 32'({obs_gnt1, obs_gnt0}), (k % 2 == 0) ? 32'h1 : 32'h2);
        end
        idle_inputs();
        cycle();

        // T4: master 1 locks for 6 beats while master 0 waits for a single beat.
        do_reset();
        a0 = 0; a1 = 0;
        for (int c = 0; c < 20; c++) begin
            drive(1, a1 < 6, 1'b0, 1'b1, 32'h8, 4'h0, 32'h0);
            drive(0, (c >= 1) && (a0 < 1), 1'b0, 1'b0, 32'hC, 4'h0, 32'h0);
            cycle();
            if (obs_ack1) begin seq.push_back(1); a1++; end
            if (obs_ack0) begin seq.push_back(0); a0++; end
        end
        check("t4_len", 32'(seq.size()), 32'd7);
        for (int i = 0; i < 7 && i < seq.size(); i++) check("t4_order", 32'(seq[i]), 32'(exp_seq[i]));
        idle_inputs();
        cycle();

        // T5: uncontended lock streams without a gap.
        do_reset();
        drive(0, 1'b1, 1'b0, 1'b1, 32'h14, 4'h0, 32'h0);
        cycle();
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("t5_ack", 32'(obs_ack0), 32'h1);
        end
        idle_inputs();
        cycle();

        // T6: owner withdraws before being acked.
        do_reset();
        drive(0, 1'b1, 1'b1, 1'b0, 32'h18, 4'hF, 32'h12345678);
        cycle();
        idle_inputs();
        cycle();
        check("t6_gnt", 32'(obs_gnt0), 32'h1);
        check("t6_noce", 32'(obs_ce), 32'h0);
        cycle();
        check("t6_idle", 32'(obs_gnt0), 32'h0);
        check("t6_mem", mem[6], exp_mem[6]);

        // Random traffic from both masters.
        do_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(0, 3) != 0) begin
                    pend[k]   = 1'b1;
                    t_we[k]   = 1'($urandom_range(0, 1));
                    t_lock[k] = ($urandom_range(0, 2) == 0);
                    t_addr[k] = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                    t_sel[k]  = 4'($urandom);
                    t_wd[k]   = $urandom;
                end
                if (pend[k]) drive(k, 1'b1, t_we[k], t_lock[k], t_addr[k], t_sel[k], t_wd[k]);
                else         drive(k, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            end
            cycle();
            if (exp_ack0) pend[0] = 1'b0;
            if (exp_ack1) pend[1] = 1'b0;
        end
        idle_inputs();
        cycle();
        for (int i = 0; i < 16; i++) check("final_mem", mem[i], exp_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
